// File: rtl/kappa3_pkg.sv
// kappa3_pkg: shared phase encodings, FSM state enum and widths for the run controller.
package kappa3_pkg;

   localparam int unsigned PHASE_W  = 4;
   localparam int unsigned WORD_W   = 32;
   localparam int unsigned DB_CNT_W = 16;

   // One-hot phase codes driven by phasegen on cstate.
   localparam logic [PHASE_W-1:0] PH_IF = 4'b0001;
   localparam logic [PHASE_W-1:0] PH_DE = 4'b0010;
   localparam logic [PHASE_W-1:0] PH_EX = 4'b0100;
   localparam logic [PHASE_W-1:0] PH_WB = 4'b1000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_START,
      ST_BUSY,
      ST_RUN,
      ST_STOPPING,
      ST_WAIT_STOP
   } run_state_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus level debouncer for one raw push-button.
// rise is a registered one-cycle strobe on each accepted 0->1 transition.
module btn_debounce
   import kappa3_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic rise
);

   localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                sync_0;
   logic                sync_1;
   logic                level;
   logic [DB_CNT_W-1:0] cnt;

   // Synchronize, then accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync_0 <= 1'b0;
         sync_1 <= 1'b0;
         level  <= 1'b0;
         cnt    <= '0;
         rise   <= 1'b0;
      end else begin
         sync_0 <= btn;
         sync_1 <= sync_0;
         rise   <= 1'b0;
         if (sync_1 != level) begin
            if (cnt == CNT_LAST) begin
               level <= sync_1;
               rise  <= sync_1;
               cnt   <= '0;
            end else begin
               cnt <= cnt + DB_CNT_W'(1);
            end
         end else begin
            // Any bounce back to the accepted level restarts the count.
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: turns debounced run / step-instruction / step-phase buttons into single-cycle
// commands for phasegen, stops free-running execution on an instruction boundary (by request
// or breakpoint) and optionally counts completed instructions.
// Optional feature macro: RUN_CTRL_INST_COUNT_EN (enables the inst_count register).
module run_ctrl
   import kappa3_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                btn_run,
   input  logic                btn_step_inst,
   input  logic                btn_step_phase,
   input  logic [PHASE_W-1:0]  cstate,
   input  logic                running,
   input  logic [WORD_W-1:0]   pc,
   input  logic [WORD_W-1:0]   bp_addr,
   input  logic                bp_valid,
   output logic                run_pulse,
   output logic                step_inst_pulse,
   output logic                step_phase_pulse,
   output logic                halted_bp,
   output logic [WORD_W-1:0]   inst_count
);

   logic       rise_run;
   logic       rise_inst;
   logic       rise_phase;

   run_state_t state;
   logic       cmd_is_run;
   logic       start_wait;
   logic       skip_if;
   logic       stop_bp;

   logic       any_req_c;
   logic       bp_hit_c;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
      .clock (clock),
      .reset (reset),
      .btn   (btn_run),
      .rise  (rise_run)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inst (
      .clock (clock),
      .reset (reset),
      .btn   (btn_step_inst),
      .rise  (rise_inst)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_phase (
      .clock (clock),
      .reset (reset),
      .btn   (btn_step_phase),
      .rise  (rise_phase)
   );

   // Request and breakpoint decode; the IF the run started from never counts as a hit.
   always_comb begin
      any_req_c = rise_run | rise_inst | rise_phase;
      bp_hit_c  = bp_valid && (cstate == PH_IF) && (pc == bp_addr) && !skip_if;
   end

   // Command sequencer: all pulses default low so each one lasts exactly one cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state            <= ST_IDLE;
         run_pulse        <= 1'b0;
         step_inst_pulse  <= 1'b0;
         step_phase_pulse <= 1'b0;
         halted_bp        <= 1'b0;
         cmd_is_run       <= 1'b0;
         start_wait       <= 1'b0;
         skip_if          <= 1'b0;
         stop_bp          <= 1'b0;
      end else begin
         run_pulse        <= 1'b0;
         step_inst_pulse  <= 1'b0;
         step_phase_pulse <= 1'b0;

         // Leaving the starting IF re-arms breakpoint matching.
         if (skip_if && running && (cstate != PH_IF)) begin
            skip_if <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (any_req_c && !running) begin
                  halted_bp  <= 1'b0;
                  start_wait <= 1'b0;
                  stop_bp    <= 1'b0;
                  state      <= ST_WAIT_START;
                  if (rise_phase) begin
                     step_phase_pulse <= 1'b1;
                     cmd_is_run       <= 1'b0;
                     skip_if          <= 1'b0;
                  end else if (rise_inst) begin
                     step_inst_pulse <= 1'b1;
                     cmd_is_run      <= 1'b0;
                     skip_if         <= 1'b0;
                  end else begin
                     run_pulse  <= 1'b1;
                     cmd_is_run <= 1'b1;
                     skip_if    <= 1'b1;
                  end
               end
            end

            ST_WAIT_START: begin
               if (running) begin
                  state <= cmd_is_run ? ST_RUN : ST_BUSY;
               end else if (start_wait) begin
                  state <= ST_IDLE;
               end else begin
                  start_wait <= 1'b1;
               end
            end

            ST_BUSY: begin
               if (!running) begin
                  state <= ST_IDLE;
               end
            end

            ST_RUN: begin
               if (!running) begin
                  state <= ST_IDLE;
               end else if (bp_hit_c || rise_run) begin
                  stop_bp <= bp_hit_c;
                  state   <= ST_STOPPING;
               end
            end

            ST_STOPPING: begin
               // Pulse registered at EX lands in WB, so phasegen halts at the next IF.
               if (!running) begin
                  state <= ST_IDLE;
               end else if (cstate == PH_EX) begin
                  run_pulse <= 1'b1;
                  state     <= ST_WAIT_STOP;
               end
            end

            ST_WAIT_STOP: begin
               if (!running) begin
                  halted_bp <= stop_bp;
                  state     <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef RUN_CTRL_INST_COUNT_EN
   // Completed-instruction counter: one count per executed WB phase, wrapping mod 2^32.
   always_ff @(posedge clock) begin
      if (!reset) begin
         inst_count <= '0;
      end else if (running && (cstate == PH_WB)) begin
         inst_count <= inst_count + WORD_W'(1);
      end
   end
`else
   assign inst_count = '0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: self-checking bench for run_ctrl with a behavioural phasegen model.
module tb_run_ctrl;
   import kappa3_pkg::*;

   localparam int unsigned DB = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        btn_run = 1'b0;
   logic        btn_step_inst = 1'b0;
   logic        btn_step_phase = 1'b0;
   logic [3:0]  cstate;
   logic        running;
   logic [31:0] pc = 32'h0;
   logic [31:0] bp_addr = 32'h0;
   logic        bp_valid = 1'b0;
   logic        run_pulse;
   logic        step_inst_pulse;
   logic        step_phase_pulse;
   logic        halted_bp;
   logic [31:0] inst_count;

   int n_tests = 0;
   int n_fail  = 0;
   int n_run, n_inst, n_phase;
   int onehot_bad = 0;

   logic        pc_load = 1'b0;
   logic [31:0] pc_load_val = 32'h0;
   int          remain;
   logic        run_mode;
   logic [31:0] exp_ic;

   run_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
      .clock            (clock),
      .reset            (reset),
      .btn_run          (btn_run),
      .btn_step_inst    (btn_step_inst),
      .btn_step_phase   (btn_step_phase),
      .cstate           (cstate),
      .running          (running),
      .pc               (pc),
      .bp_addr          (bp_addr),
      .bp_valid         (bp_valid),
      .run_pulse        (run_pulse),
      .step_inst_pulse  (step_inst_pulse),
      .step_phase_pulse (step_phase_pulse),
      .halted_bp        (halted_bp),
      .inst_count       (inst_count)
   );

   always #5 clock = ~clock;

   // Phasegen model: run = free-running until a run pulse lands in WB, step_inst = 4 phases,
   // step_phase = 1 phase. pc loops 0x10 -> 0x14 -> 0x18 -> 0x10, otherwise +4 per instruction.
   always @(posedge clock) begin
      if (pc_load) pc <= pc_load_val;
      else if (running && cstate == PH_WB) pc <= (pc == 32'h18) ? 32'h10 : pc + 32'd4;
      if (!reset) begin
         running  <= 1'b0;
         cstate   <= PH_IF;
         remain   <= 0;
         run_mode <= 1'b0;
      end else if (!running) begin
         if (run_pulse) begin
            running <= 1'b1; run_mode <= 1'b1;
         end else if (step_inst_pulse) begin
            running <= 1'b1; run_mode <= 1'b0; remain <= 4;
         end else if (step_phase_pulse) begin
            running <= 1'b1; run_mode <= 1'b0; remain <= 1;
         end
      end else begin
         cstate <= {cstate[2:0], cstate[3]};
         if (run_mode) begin
            if (run_pulse && cstate == PH_WB) running <= 1'b0;
         end else begin
            remain <= remain - 1;
            if (remain == 1) running <= 1'b0;
         end
      end
   end

   // Expected instruction count: executed WB phases since reset.
   always @(posedge clock) begin
      if (!reset) exp_ic <= 32'h0;
      else if (running && cstate == PH_WB) exp_ic <= exp_ic + 32'd1;
   end

   // At most one command pulse per cycle.
   always @(negedge clock) begin
      if ((int'(run_pulse) + int'(step_inst_pulse) + int'(step_phase_pulse)) > 1)
         onehot_bad <= onehot_bad + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      n_run   += int'(run_pulse);
      n_inst  += int'(step_inst_pulse);
      n_phase += int'(step_phase_pulse);
   endtask

   task automatic clr();
      n_run = 0; n_inst = 0; n_phase = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      btn_run = 1'b0; btn_step_inst = 1'b0; btn_step_phase = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (running && k < 200) begin
         tick();
         k++;
      end
      if (running) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: running still 1 after 200 cycles, expected 0", name);
      end
      repeat (10) tick();
   endtask

   function automatic logic raw_at(input logic [59:0] raw, input int idx);
      if (idx < 0 || idx > 59) return 1'b0;
      return raw[idx];
   endfunction

   typedef struct {
      logic run;
      logic inst;
      logic phase;
      int   exp_run;
      int   exp_inst;
      int   exp_phase;
   } vec_t;

   vec_t tbl[7];

   initial begin
      logic [31:0]  exp_cnt;
      logic [3:0]   cs_before;
      logic [3:0]   cs_exp;
      int           bad;
      int           wbs;
      logic         seen_run;
      int           k;

`ifdef RUN_CTRL_INST_COUNT_EN
      exp_cnt = 32'd5;
`else
      exp_cnt = 32'd0;
`endif

      tbl[0] = '{1'b0, 1'b0, 1'b1, 0, 0, 1};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 0, 1, 0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1, 0, 0};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 0, 1, 0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 0, 0, 1};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 0, 0, 1};
      tbl[6] = '{1'b1, 1'b1, 1'b1, 0, 0, 1};

      // Reset values.
      clr();
      do_reset();
      check("reset_run_pulse", 128'(run_pulse), 128'(0));
      check("reset_step_inst_pulse", 128'(step_inst_pulse), 128'(0));
      check("reset_step_phase_pulse", 128'(step_phase_pulse), 128'(0));
      check("reset_halted_bp", 128'(halted_bp), 128'(0));
      check("reset_inst_count", 128'(inst_count), 128'(0));

      // Five step_inst commands from reset.
      clr();
      for (int i = 0; i < 5; i++) begin
         btn_step_inst = 1'b1;
         repeat (10) tick();
         btn_step_inst = 1'b0;
         wait_idle("step_inst_idle");
      end
      check("five_step_inst_pulses", 128'(n_inst), 128'(5));
      check("five_step_inst_other", 128'(n_run + n_phase), 128'(0));
      check("inst_count_after_5", 128'(inst_count), 128'(exp_cnt));

      // Bounce 1,0,1 then hold: one pulse, none before the stable window completes.
      clr();
      btn_step_phase = 1'b1; tick();
      btn_step_phase = 1'b0; tick();
      btn_step_phase = 1'b1; tick();
      repeat (5) tick();
      check("bounce_no_early_pulse", 128'(n_phase), 128'(0));
      repeat (20) tick();
      check("bounce_one_pulse", 128'(n_phase), 128'(1));
      check("bounce_other_pulses", 128'(n_run + n_inst), 128'(0));
      btn_step_phase = 1'b0;
      wait_idle("bounce_idle");

      // Simultaneous button combinations: priority step_phase > step_inst > run.
      foreach (tbl[i]) begin
         cs_before = cstate;
         clr();
         btn_run = tbl[i].run; btn_step_inst = tbl[i].inst; btn_step_phase = tbl[i].phase;
         repeat (12) tick();
         btn_run = 1'b0; btn_step_inst = 1'b0; btn_step_phase = 1'b0;
         repeat (10) tick();
         check($sformatf("combo%0d_run", i), 128'(n_run), 128'(tbl[i].exp_run));
         check($sformatf("combo%0d_inst", i), 128'(n_inst), 128'(tbl[i].exp_inst));
         check($sformatf("combo%0d_phase", i), 128'(n_phase), 128'(tbl[i].exp_phase));
         if (tbl[i].exp_run != 0) begin
            btn_run = 1'b1;
            repeat (12) tick();
            btn_run = 1'b0;
            cs_exp = PH_IF;
         end else if (tbl[i].exp_inst != 0) begin
            cs_exp = cs_before;
         end else begin
            cs_exp = {cs_before[2:0], cs_before[3]};
         end
         wait_idle("combo_idle");
         check($sformatf("combo%0d_cstate", i), 128'(cstate), 128'(cs_exp));
      end

      // Run, then a second run press landing in DE: stop pulse only in WB.
      btn_run = 1'b1; repeat (12) tick(); btn_run = 1'b0;
      repeat (10) tick();
      clr();
      k = 0;
      while (cstate != PH_WB && k < 8) begin tick(); k++; end
      check("run_reached_wb", 128'(cstate), 128'(PH_WB));
      btn_run = 1'b1;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (i == 11) btn_run = 1'b0;
         if (run_pulse && cstate != PH_WB) bad++;
      end
      wait_idle("stop_idle");
      check("stop_pulse_outside_wb", 128'(bad), 128'(0));
      check("stop_run_pulses", 128'(n_run), 128'(1));
      check("stop_cstate_if", 128'(cstate), 128'(PH_IF));
      check("stop_running_low", 128'(running), 128'(0));
      check("stop_not_bp", 128'(halted_bp), 128'(0));

      // Breakpoint at 0x10, run starting at 0x10.
      do_reset();
      pc_load = 1'b1; pc_load_val = 32'h10; tick(); pc_load = 1'b0;
      bp_valid = 1'b1; bp_addr = 32'h10;
      clr();
      wbs = 0; seen_run = 1'b0;
      btn_run = 1'b1;
      for (int i = 0; i < 150; i++) begin
         tick();
         if (i == 11) btn_run = 1'b0;
         if (running && cstate == PH_WB) wbs++;
         if (running) seen_run = 1'b1;
         if (seen_run && !running && i > 11) break;
      end
      repeat (3) tick();
      check("bp_instructions_executed", 128'(wbs), 128'(4));
      check("bp_halted", 128'(halted_bp), 128'(1));
      check("bp_stop_pc", 128'(pc), 128'(32'h14));
      check("bp_stop_cstate", 128'(cstate), 128'(PH_IF));
      check("bp_run_pulses", 128'(n_run), 128'(2));
      bp_valid = 1'b0;
      btn_step_phase = 1'b1; repeat (12) tick(); btn_step_phase = 1'b0;
      wait_idle("bp_clear_idle");
      check("bp_cleared_by_command", 128'(halted_bp), 128'(0));

      // Reset asserted while stopping: no stop pulse ever appears.
      do_reset();
      btn_run = 1'b1; repeat (12) tick(); btn_run = 1'b0;
      repeat (10) tick();
      k = 0;
      while (cstate != PH_EX && k < 8) begin tick(); k++; end
      btn_run = 1'b1;
      clr();
      repeat (7) tick();
      reset = 1'b0; btn_run = 1'b0;
      tick();
      check("rst_stop_run_pulse", 128'(run_pulse), 128'(0));
      check("rst_stop_halted", 128'(halted_bp), 128'(0));
      check("rst_stop_inst_count", 128'(inst_count), 128'(0));
      reset = 1'b1;
      repeat (30) tick();
      check("rst_stop_no_pulse_after", 128'(n_run + n_inst + n_phase), 128'(0));

      // Randomized single-button bounce traces against a window-based acceptance model.
      for (int t = 0; t < 12; t++) begin
         logic [59:0]  raw;
         logic [127:0] obs;
         logic [127:0] expv;
         logic         use_inst;
         logic         lvl;
         logic         v;
         logic         all_diff;
         int           idx;
         int           others;
         int           len;
         use_inst = 1'($urandom_range(1, 0));
         v = 1'b0; idx = 0; raw = '0;
         while (idx < 60) begin
            len = int'($urandom_range(7, 1));
            v = ~v;
            for (int q = 0; q < len && idx < 60; q++) begin raw[idx] = v; idx++; end
         end
         obs = '0; others = 0;
         for (int c = 0; c < 90; c++) begin
            if (use_inst) btn_step_inst = raw_at(raw, c);
            else btn_step_phase = raw_at(raw, c);
            tick();
            obs[c + 1] = use_inst ? step_inst_pulse : step_phase_pulse;
            others += int'(run_pulse) + int'(use_inst ? step_phase_pulse : step_inst_pulse);
         end
         btn_step_inst = 1'b0; btn_step_phase = 1'b0;
         expv = '0; lvl = 1'b0;
         for (int j = 0; j < 90; j++) begin
            all_diff = 1'b1;
            for (int q = 0; q < int'(DB); q++)
               if (raw_at(raw, j - q) == lvl) all_diff = 1'b0;
            if (all_diff) begin
               lvl = ~lvl;
               if (lvl) expv[j + 4] = 1'b1;
            end
         end
         check($sformatf("rand%0d_pulse_trace", t), obs, expv);
         check($sformatf("rand%0d_other_pulses", t), 128'(others), 128'(0));
         wait_idle("rand_idle");
      end

`ifdef RUN_CTRL_INST_COUNT_EN
      check("final_inst_count", 128'(inst_count), 128'(exp_ic));
`else
      check("final_inst_count", 128'(inst_count), 128'(0));
`endif
      check("pulses_onehot", 128'(onehot_bad), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
